ladybird_bus_arbiter: RTL and testbench
=======================================

Name: ladybird_bus_arbiter

Overview:
- Synthesizable N-input to 1-output arbiter for the ladybird req/gnt memory bus. Successor to the behavioural two-input arbitrator.
- Adds selectable fixed-priority or round-robin policy, grant locking, and in-order response routing through an outstanding-ID FIFO.
- Sits between the core/loader masters and a single RAM or peripheral slave.

Parameters:
- N_INPUT, 2, number of masters (>=1); IDX_W = max(1, $clog2(N_INPUT)).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width DATA_W/8.
- MAX_OUTSTANDING, 4, depth of the response-routing FIFO (power of two, >=1).
- ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock
- anrst  in  1  asynchronous active-low reset
- nrst  in  1  synchronous active-low reset; same clearing effect as anrst
- in_req  in  N_INPUT  per-master request
- in_addr  in  N_INPUT*ADDR_W  per-master address
- in_wstrb  in  N_INPUT*DATA_W/8  per-master write strobe; 0 means read
- in_wdata  in  N_INPUT*DATA_W  per-master write data
- in_gnt  out  N_INPUT  per-master grant
- in_rvalid  out  N_INPUT  per-master response valid
- in_rdata  out  DATA_W  response data, broadcast to all masters
- out_req  out  1  downstream request
- out_addr  out  ADDR_W  downstream address
- out_wstrb  out  DATA_W/8  downstream strobe
- out_wdata  out  DATA_W  downstream write data
- out_gnt  in  1  downstream grant
- out_rvalid  in  1  downstream response valid; one per accepted request, in order
- out_rdata  in  DATA_W  downstream response data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  FIFO occupancy
- err_unexpected  out  1  sticky: out_rvalid received while FIFO empty

Behaviour:
- Handshake:
  - A transfer occurs on a rising clk edge where out_req && out_gnt.
  - Masters hold req and all fields stable until their gnt.
  - in_gnt[i] = out_gnt && out_req && (sel == i), combinational.
- Selection, when not locked:
  - Fixed priority: lowest set in_req index.
  - Round-robin: first set in_req at or after rr_ptr, wrapping modulo N_INPUT.
- Lock: if out_req=1 and out_gnt=0 at an edge, the register locked=1 and lock_idx = sel. Selection stays on lock_idx until the handshake.
- Lock release:
  - Lock clears on the handshake edge.
  - If the locked master drops req (protocol violation), lock releases the next cycle.
- rr_ptr: on each handshake, rr_ptr <= (sel+1) mod N_INPUT. Unused in fixed mode.
- Downstream mux: out_req = |in_req && !fifo_full. out_addr, out_wstrb and out_wdata mux from sel.
  - When out_req=0, these outputs are all zero.
- ID FIFO:
  - Push sel on handshake; pop on out_rvalid.
  - fifo_full means count == MAX_OUTSTANDING and blocks out_req even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Response routing: in_rvalid[head] = out_rvalid && !empty. in_rdata = out_rdata (pass-through, zero latency).
- Unexpected response: out_rvalid with FIFO empty is dropped, with no in_rvalid. err_unexpected sets and holds until reset.
- Latency: zero-cycle combinational request path. Responses also pass through combinationally.
- Reset (anrst=0 async, or nrst=0 at an edge):
  - Clears count, pointers, rr_ptr, locked and err_unexpected.
  - Resulting outputs: all gnt/rvalid 0, out_req 0, outstanding 0.
  - Reset mid-transfer discards all outstanding IDs.

Decomposition:
- ladybird_config additions: bus strobe width constant. The arb_mode enum (ARB_FIXED, ARB_RR) maps onto ROUND_ROBIN.
- One sub-module: ladybird_id_fifo.
  - Parameters: WIDTH=IDX_W, DEPTH.
  - Ports: push, pop, full, empty, count, head.
  - Same clk/anrst/nrst reset ports.

Test Plan:
- Single master 0 writes addr 0x4, data 0xbeafcafe, wstrb 0xF, with the RAM model granting -> one handshake, outstanding returns to 0, and a readback of 0x4 delivers in_rvalid[0] with 0xbeafcafe.
- ROUND_ROBIN=1, N_INPUT=3, all three reqs held for 6 transfers -> grant order 0,1,2,0,1,2. With ROUND_ROBIN=0 under the same stimulus -> 0 granted six times.
- Slave holds out_gnt=0 for 3 cycles while master 0 waits, and master 1 raises req at cycle 1 -> sel stays 0 until the handshake, then master 1 is served.
- MAX_OUTSTANDING=2, slave withholds rvalid -> two handshakes, then out_req=0 with pending reqs. One out_rvalid -> outstanding 1, and out_req reasserts the next cycle.
- Interleaved reads: master 0 then master 1, responses 0x11111111 then 0x22222222 -> in_rvalid[0] carries the first, in_rvalid[1] the second.
- out_rvalid pulse with empty FIFO -> no in_rvalid and err_unexpected=1. Then anrst pulse -> err_unexpected=0 and outstanding=0.

Source files
------------

// File: rtl/ladybird_bus_arbiter_pkg.sv
// Shared types, constants and helpers for the ladybird req/gnt bus arbiter.
package ladybird_bus_arbiter_pkg;

  // Arbitration policy, fixed at elaboration from the ROUND_ROBIN parameter.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Data bits covered by one write-strobe bit.
  localparam int BUS_STRB_GRAN = 8;

  // Write-strobe width for a given bus data width.
  function automatic int strb_w(input int data_w);
    return data_w / BUS_STRB_GRAN;
  endfunction

  // Width of a master index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Map the integer policy parameter onto the policy enum.
  function automatic arb_mode_e arb_mode(input int round_robin);
    return (round_robin != 0) ? ARB_RR : ARB_FIXED;
  endfunction

endpackage

// File: rtl/ladybird_id_fifo.sv
// Outstanding-request ID FIFO: remembers which master owns each accepted
// request so responses, which come back in order, can be routed home.
module ladybird_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         anrst,
  input  logic                         nrst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_id,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer/count update; a full FIFO refuses push even when popping.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Synchronous clear discards every outstanding ID.
    if (!nrst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// N-to-1 arbiter for the ladybird req/gnt bus: fixed-priority or
// round-robin selection, grant locking while the slave stalls, and
// in-order response routing through an outstanding-ID FIFO.
module ladybird_bus_arbiter
  import ladybird_bus_arbiter_pkg::*;
#(
  parameter int N_INPUT         = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic                                      clk,
  input  logic                                      anrst,
  input  logic                                      nrst,
  input  logic [N_INPUT-1:0]                        in_req,
  input  logic [N_INPUT-1:0][ADDR_W-1:0]            in_addr,
  input  logic [N_INPUT-1:0][strb_w(DATA_W)-1:0]    in_wstrb,
  input  logic [N_INPUT-1:0][DATA_W-1:0]            in_wdata,
  output logic [N_INPUT-1:0]                        in_gnt,
  output logic [N_INPUT-1:0]                        in_rvalid,
  output logic [DATA_W-1:0]                         in_rdata,
  output logic                                      out_req,
  output logic [ADDR_W-1:0]                         out_addr,
  output logic [strb_w(DATA_W)-1:0]                 out_wstrb,
  output logic [DATA_W-1:0]                         out_wdata,
  input  logic                                      out_gnt,
  input  logic                                      out_rvalid,
  input  logic [DATA_W-1:0]                         out_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
  output logic                                      err_unexpected
);

  localparam int        IDX_W  = idx_w(N_INPUT);
  localparam int        STRB_W = strb_w(DATA_W);
  localparam int        CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam arb_mode_e MODE   = arb_mode(ROUND_ROBIN);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] sel_free;
  logic [IDX_W-1:0] sel;
  logic             found;
  int               cand;
  logic             hs;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Pick a master: free choice by policy, or the locked one while stalled.
  always_comb begin
    sel_free = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N_INPUT; k++) begin
      if (MODE == ARB_RR) cand = (int'(rr_ptr_q) + k) % N_INPUT;
      else                cand = k;
      if (!found && in_req[IDX_W'(cand)]) begin
        found    = 1'b1;
        sel_free = IDX_W'(cand);
      end
    end
    sel = locked_q ? lock_idx_q : sel_free;
  end

  // A full ID FIFO stalls new requests so every response has an owner.
  assign out_req = (|in_req) && !fifo_full;
  assign hs      = out_req && out_gnt;

  // Forward the selected master's fields; drive zeros when idle.
  always_comb begin
    out_addr  = '0;
    out_wstrb = '0;
    out_wdata = '0;
    if (out_req) begin
      out_addr  = in_addr[sel];
      out_wstrb = in_wstrb[sel];
      out_wdata = in_wdata[sel];
    end
  end

  // Per-master grant and response-valid decode.
  for (genvar i = 0; i < N_INPUT; i++) begin : g_lane
    assign in_gnt[i]    = hs && (sel == IDX_W'(i));
    assign in_rvalid[i] = out_rvalid && !fifo_empty && (fifo_head == IDX_W'(i));
  end

  assign in_rdata       = out_rdata;
  assign outstanding    = fifo_count;
  assign err_unexpected = err_q;

  // Next-state for rotation pointer, grant lock and sticky error flag.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q | (out_rvalid && fifo_empty);
    if (hs) begin
      rr_ptr_d = (int'(sel) == N_INPUT - 1) ? '0 : sel + IDX_W'(1);
    end
    if (hs) begin
      locked_d = 1'b0;
    end else if (locked_q && !in_req[lock_idx_q]) begin
      // Locked master gave up without a grant; let others compete again.
      locked_d = 1'b0;
    end else if (out_req && !out_gnt) begin
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end
    if (!nrst) begin
      rr_ptr_d   = '0;
      locked_d   = 1'b0;
      lock_idx_d = '0;
      err_d      = 1'b0;
    end
  end

  // Arbiter state registers with asynchronous clear.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  ladybird_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .anrst   (anrst),
    .nrst    (nrst),
    .push    (hs),
    .push_id (sel),
    .pop     (out_rvalid),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  logic unused_strb_w;
  assign unused_strb_w = (STRB_W == 0);

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one
// stimulus stream (N_INPUT=3, MAX_OUTSTANDING=2).
module tb_ladybird_bus_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic anrst, nrst;
  logic [N-1:0]         in_req;
  logic [N-1:0][31:0]   in_addr;
  logic [N-1:0][3:0]    in_wstrb;
  logic [N-1:0][31:0]   in_wdata;
  logic                 out_gnt, out_rvalid;
  logic [31:0]          out_rdata;

  logic [N-1:0] gnt_rr, gnt_fx, rv_rr, rv_fx;
  logic [31:0]  rdata_rr, rdata_fx, oaddr_rr, oaddr_fx, owdata_rr, owdata_fx;
  logic [3:0]   owstrb_rr, owstrb_fx;
  logic         oreq_rr, oreq_fx, err_rr, err_fx;
  logic [1:0]   outst_rr, outst_fx;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  ladybird_bus_arbiter #(.N_INPUT(N), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .anrst(anrst), .nrst(nrst), .in_req(in_req), .in_addr(in_addr), .in_wstrb(in_wstrb),
    .in_wdata(in_wdata), .in_gnt(gnt_rr), .in_rvalid(rv_rr), .in_rdata(rdata_rr), .out_req(oreq_rr),
    .out_addr(oaddr_rr), .out_wstrb(owstrb_rr), .out_wdata(owdata_rr), .out_gnt(out_gnt),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata), .outstanding(outst_rr), .err_unexpected(err_rr));

  ladybird_bus_arbiter #(.N_INPUT(N), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(0)) u_fx (
    .clk(clk), .anrst(anrst), .nrst(nrst), .in_req(in_req), .in_addr(in_addr), .in_wstrb(in_wstrb),
    .in_wdata(in_wdata), .in_gnt(gnt_fx), .in_rvalid(rv_fx), .in_rdata(rdata_fx), .out_req(oreq_fx),
    .out_addr(oaddr_fx), .out_wstrb(owstrb_fx), .out_wdata(owdata_fx), .out_gnt(out_gnt),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata), .outstanding(outst_fx), .err_unexpected(err_fx));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_rvalid = 1'b1;
    #3;
    total++; if (outst_rr !== 2'd0 || outst_fx !== 2'd0) begin bad++; $display("FAIL reset_outst got=%0d/%0d want=0", outst_rr, outst_fx); end
    total++; if (err_rr !== 1'b0 || err_fx !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b want=0", err_rr, err_fx); end
    total++; if (oreq_rr !== 1'b0 || oreq_fx !== 1'b0) begin bad++; $display("FAIL reset_oreq got=%b/%b want=0", oreq_rr, oreq_fx); end
    total++; if (gnt_rr !== 3'b000 || gnt_fx !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b/%b want=000", gnt_rr, gnt_fx); end
    total++; if (rv_rr !== 3'b000 || rv_fx !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b/%b want=000", rv_rr, rv_fx); end
    out_rvalid = 1'b0;
    #4 anrst = 1'b1;
    cyc();
    total++; if (err_rr !== 1'b0) begin bad++; $display("FAIL reset_err_after got=%b want=0", err_rr); end
  endtask

  task automatic test_single();
    in_addr[0] = 32'h4; in_wstrb[0] = 4'hF; in_wdata[0] = 32'hbeafcafe;
    in_req = 3'b001; out_gnt = 1'b1;
    #1;
    total++; if (gnt_rr !== 3'b001 || gnt_fx !== 3'b001) begin bad++; $display("FAIL wr_gnt got=%b/%b want=001", gnt_rr, gnt_fx); end
    total++; if (oaddr_rr !== 32'h4 || owdata_rr !== 32'hbeafcafe || owstrb_rr !== 4'hF) begin bad++; $display("FAIL wr_fields got=%h/%h/%h want=4/beafcafe/f", oaddr_rr, owdata_rr, owstrb_rr); end
    mem_word = in_wdata[0];
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1;
    #1;
    total++; if (outst_rr !== 2'd1) begin bad++; $display("FAIL wr_outst got=%0d want=1", outst_rr); end
    total++; if (rv_rr !== 3'b001) begin bad++; $display("FAIL wr_ack got=%b want=001", rv_rr); end
    total++; if (oreq_rr !== 1'b0 || oaddr_rr !== 32'h0) begin bad++; $display("FAIL idle_zero got=%b/%h want=0/0", oreq_rr, oaddr_rr); end
    cyc();
    out_rvalid = 1'b0; in_wstrb[0] = 4'h0; in_req = 3'b001; out_gnt = 1'b1;
    #1;
    total++; if (outst_rr !== 2'd0) begin bad++; $display("FAIL wr_drain got=%0d want=0", outst_rr); end
    total++; if (gnt_rr !== 3'b001 || owstrb_rr !== 4'h0) begin bad++; $display("FAIL rd_req got=%b/%h want=001/0", gnt_rr, owstrb_rr); end
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1; out_rdata = mem_word;
    #1;
    total++; if (rv_rr !== 3'b001 || rdata_rr !== 32'hbeafcafe) begin bad++; $display("FAIL rd_resp got=%b/%h want=001/beafcafe", rv_rr, rdata_rr); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd0) begin bad++; $display("FAIL rd_drain got=%0d want=0", outst_rr); end
    cyc();
  endtask

  task automatic test_lock();
    in_addr[0] = 32'h100; in_addr[1] = 32'h200; in_addr[2] = 32'h300;
    in_req = 3'b001; out_gnt = 1'b0;
    #1;
    total++; if (oaddr_rr !== 32'h100 || gnt_rr !== 3'b000 || oreq_rr !== 1'b1) begin bad++; $display("FAIL lock_c0 got=%h/%b/%b want=100/000/1", oaddr_rr, gnt_rr, oreq_rr); end
    cyc();
    in_req = 3'b011;
    #1;
    total++; if (oaddr_rr !== 32'h100 || oaddr_fx !== 32'h100) begin bad++; $display("FAIL lock_c1 got=%h/%h want=100", oaddr_rr, oaddr_fx); end
    cyc();
    #1;
    total++; if (oaddr_rr !== 32'h100) begin bad++; $display("FAIL lock_c2 got=%h want=100", oaddr_rr); end
    cyc();
    out_gnt = 1'b1;
    #1;
    total++; if (gnt_rr !== 3'b001 || gnt_fx !== 3'b001) begin bad++; $display("FAIL lock_hs got=%b/%b want=001", gnt_rr, gnt_fx); end
    cyc();
    in_req = 3'b010;
    #1;
    total++; if (gnt_rr !== 3'b010 || gnt_fx !== 3'b010 || oaddr_rr !== 32'h200) begin bad++; $display("FAIL lock_next got=%b/%b/%h want=010/010/200", gnt_rr, gnt_fx, oaddr_rr); end
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1;
    #1;
    total++; if (outst_rr !== 2'd2 || rv_rr !== 3'b001) begin bad++; $display("FAIL lock_resp0 got=%0d/%b want=2/001", outst_rr, rv_rr); end
    cyc();
    #1;
    total++; if (rv_rr !== 3'b010) begin bad++; $display("FAIL lock_resp1 got=%b want=010", rv_rr); end
    cyc();
    out_rvalid = 1'b0;
    cyc();
  endtask

  task automatic test_nrst();
    in_req = 3'b001; out_gnt = 1'b1;
    #1;
    total++; if (gnt_rr !== 3'b001) begin bad++; $display("FAIL nrst_hs got=%b want=001", gnt_rr); end
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; nrst = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd1) begin bad++; $display("FAIL nrst_before got=%0d want=1", outst_rr); end
    cyc();
    nrst = 1'b1;
    #1;
    total++; if (outst_rr !== 2'd0 || outst_fx !== 2'd0) begin bad++; $display("FAIL nrst_clear got=%0d/%0d want=0", outst_rr, outst_fx); end
    cyc();
  endtask

  task automatic test_arb_order();
    logic [N-1:0] rr_exp [6];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    in_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      out_gnt = 1'b1; out_rvalid = (t > 0);
      #1;
      total++; if (gnt_rr !== rr_exp[t]) begin bad++; $display("FAIL rr_order[%0d] got=%b want=%b", t, gnt_rr, rr_exp[t]); end
      total++; if (gnt_fx !== 3'b001) begin bad++; $display("FAIL fx_order[%0d] got=%b want=001", t, gnt_fx); end
      if (t > 0) begin
        total++; if (rv_rr !== rr_exp[t-1] || rv_fx !== 3'b001) begin bad++; $display("FAIL order_resp[%0d] got=%b/%b want=%b/001", t, rv_rr, rv_fx, rr_exp[t-1]); end
      end
      cyc();
    end
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1;
    #1;
    total++; if (rv_rr !== 3'b100 || rv_fx !== 3'b001) begin bad++; $display("FAIL order_last got=%b/%b want=100/001", rv_rr, rv_fx); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd0 || outst_fx !== 2'd0) begin bad++; $display("FAIL order_drain got=%0d/%0d want=0", outst_rr, outst_fx); end
    cyc();
  endtask

  task automatic test_full();
    in_req = 3'b011; out_gnt = 1'b1; out_rvalid = 1'b0;
    #1;
    total++; if (gnt_rr !== 3'b001 || gnt_fx !== 3'b001) begin bad++; $display("FAIL full_hs0 got=%b/%b want=001", gnt_rr, gnt_fx); end
    cyc();
    in_req = 3'b110;
    #1;
    total++; if (gnt_rr !== 3'b010 || gnt_fx !== 3'b010) begin bad++; $display("FAIL full_hs1 got=%b/%b want=010", gnt_rr, gnt_fx); end
    cyc();
    in_req = 3'b100;
    #1;
    total++; if (oreq_rr !== 1'b0 || oreq_fx !== 1'b0 || gnt_rr !== 3'b000 || oaddr_rr !== 32'h0) begin bad++; $display("FAIL full_block got=%b/%b/%b/%h want=0/0/000/0", oreq_rr, oreq_fx, gnt_rr, oaddr_rr); end
    total++; if (outst_rr !== 2'd2) begin bad++; $display("FAIL full_cnt got=%0d want=2", outst_rr); end
    cyc();
    out_rvalid = 1'b1;
    #1;
    total++; if (oreq_rr !== 1'b0 || rv_rr !== 3'b001) begin bad++; $display("FAIL full_pop got=%b/%b want=0/001", oreq_rr, rv_rr); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd1 || oreq_rr !== 1'b1 || gnt_rr !== 3'b100 || gnt_fx !== 3'b100) begin bad++; $display("FAIL full_resume got=%0d/%b/%b/%b want=1/1/100/100", outst_rr, oreq_rr, gnt_rr, gnt_fx); end
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1;
    #1;
    total++; if (rv_rr !== 3'b010) begin bad++; $display("FAIL full_resp1 got=%b want=010", rv_rr); end
    cyc();
    #1;
    total++; if (rv_rr !== 3'b100) begin bad++; $display("FAIL full_resp2 got=%b want=100", rv_rr); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd0) begin bad++; $display("FAIL full_drain got=%0d want=0", outst_rr); end
    cyc();
  endtask

  task automatic test_interleave();
    in_addr[0] = 32'h10; in_addr[1] = 32'h20; in_wstrb = '0;
    in_req = 3'b001; out_gnt = 1'b1;
    #1;
    total++; if (gnt_rr !== 3'b001) begin bad++; $display("FAIL il_hs0 got=%b want=001", gnt_rr); end
    cyc();
    in_req = 3'b010;
    #1;
    total++; if (gnt_rr !== 3'b010 || oaddr_rr !== 32'h20) begin bad++; $display("FAIL il_hs1 got=%b/%h want=010/20", gnt_rr, oaddr_rr); end
    cyc();
    in_req = 3'b000; out_gnt = 1'b0; out_rvalid = 1'b1; out_rdata = 32'h11111111;
    #1;
    total++; if (rv_rr !== 3'b001 || rdata_rr !== 32'h11111111 || rdata_fx !== 32'h11111111) begin bad++; $display("FAIL il_resp0 got=%b/%h want=001/11111111", rv_rr, rdata_rr); end
    cyc();
    out_rdata = 32'h22222222;
    #1;
    total++; if (rv_rr !== 3'b010 || rdata_rr !== 32'h22222222) begin bad++; $display("FAIL il_resp1 got=%b/%h want=010/22222222", rv_rr, rdata_rr); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (outst_rr !== 2'd0 || err_rr !== 1'b0) begin bad++; $display("FAIL il_drain got=%0d/%b want=0/0", outst_rr, err_rr); end
    cyc();
  endtask

  task automatic test_unexpected();
    out_rvalid = 1'b1; out_rdata = 32'hdead0000;
    #1;
    total++; if (rv_rr !== 3'b000 || rv_fx !== 3'b000) begin bad++; $display("FAIL unexp_drop got=%b/%b want=000", rv_rr, rv_fx); end
    cyc();
    out_rvalid = 1'b0;
    #1;
    total++; if (err_rr !== 1'b1 || err_fx !== 1'b1) begin bad++; $display("FAIL unexp_err got=%b/%b want=1", err_rr, err_fx); end
    cyc();
    #1;
    total++; if (err_rr !== 1'b1) begin bad++; $display("FAIL unexp_sticky got=%b want=1", err_rr); end
    anrst = 1'b0;
    #1;
    anrst = 1'b1;
    #1;
    total++; if (err_rr !== 1'b0 || err_fx !== 1'b0 || outst_rr !== 2'd0) begin bad++; $display("FAIL unexp_clear got=%b/%b/%0d want=0/0/0", err_rr, err_fx, outst_rr); end
    cyc();
  endtask

  initial begin
    anrst = 1'b0; nrst = 1'b1;
    in_req = '0; in_addr = '0; in_wstrb = '0; in_wdata = '0;
    out_gnt = 1'b0; out_rvalid = 1'b0; out_rdata = '0; mem_word = '0;
    test_reset();
    test_single();
    test_lock();
    test_nrst();
    test_arb_order();
    test_full();
    test_interleave();
    test_unexpected();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
